// File: rtl/rename_free_list.sv
// rename_free_list
//   Physical-register free list for the rename stage. It is a circular FIFO of
//   free tags with three pointers:
//     headPtr       - speculative head, which advances as dispatch allocates
//     commitHeadPtr - head as seen by retirement, the rollback target on flush
//     tailPtr       - where retired (released) tags are written back
//   Allocation reads are combinational, so tags appear in the same cycle as the
//   request. Releases become visible from the next cycle onward.
// Ports
//   clk, reset          : clock, async active-high reset
//   flush_i             : mispredict recovery, which rolls the head back to the committed head
//   allocReady_i        : dispatch bundle valid and backend not stalled
//   reqVector_i         : per-slot "needs a destination register"
//   freeValid_i         : per-slot release valid
//   freeReg0_i..3_i     : released tags
//   commitAllocCnt_i    : allocations retired this cycle (0..4)
//   physReg0_o..3_o     : allocated tag per slot (0 when the slot does not request)
//   stallFreeList_o     : fewer than DISPATCH_WIDTH free tags
//   freeCount_o         : speculative free count

// Per-lane read port. The lane's offset into the list is the number of
// requesting slots below it, so the tags pack densely from the head.
module rename_free_list_lane #(
  parameter int LANE         = 0,
  parameter int FREE_ENTRIES = 64,
  parameter int FREE_LOG     = 6,
  parameter int PHY_LOG      = 7
) (
  input  logic [LANE:0]                           reqMask,
  input  logic [FREE_LOG-1:0]                     headPtr,
  input  logic [FREE_ENTRIES-1:0][PHY_LOG-1:0]    entries,
  output logic [PHY_LOG-1:0]                      physReg
);
  logic [FREE_LOG-1:0] offset;
  logic [FREE_LOG-1:0] rdIdx;

  always_comb begin
    offset = '0;
    for (int j = 0; j < LANE; j++) offset = offset + FREE_LOG'(reqMask[j]);
    rdIdx   = headPtr + offset;                // wraps modulo FREE_ENTRIES
    physReg = reqMask[LANE] ? entries[rdIdx] : '0;
  end
endmodule

module rename_free_list #(
  parameter int PHY_REGS       = 96,
  parameter int ARCH_REGS      = 32,
  parameter int FREE_ENTRIES   = 64,
  parameter int FREE_LOG       = 6,
  parameter int PHY_LOG        = 7,
  parameter int DISPATCH_WIDTH = 4,
  parameter int COMMIT_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      allocReady_i,
  input  logic [DISPATCH_WIDTH-1:0] reqVector_i,
  input  logic [COMMIT_WIDTH-1:0]   freeValid_i,
  input  logic [PHY_LOG-1:0]        freeReg0_i,
  input  logic [PHY_LOG-1:0]        freeReg1_i,
  input  logic [PHY_LOG-1:0]        freeReg2_i,
  input  logic [PHY_LOG-1:0]        freeReg3_i,
  input  logic [2:0]                commitAllocCnt_i,
  output logic [PHY_LOG-1:0]        physReg0_o,
  output logic [PHY_LOG-1:0]        physReg1_o,
  output logic [PHY_LOG-1:0]        physReg2_o,
  output logic [PHY_LOG-1:0]        physReg3_o,
  output logic                      stallFreeList_o,
  output logic [FREE_LOG:0]         freeCount_o
);
  logic [FREE_ENTRIES-1:0][PHY_LOG-1:0]   entries;
  logic [FREE_LOG-1:0]                    headPtr, tailPtr, commitHeadPtr;
  logic [FREE_LOG:0]                      freeCount, commitCount;

  logic [COMMIT_WIDTH-1:0][PHY_LOG-1:0]   freeRegs;
  logic [DISPATCH_WIDTH-1:0][PHY_LOG-1:0] physRegs;
  logic [COMMIT_WIDTH-1:0][FREE_LOG-1:0]  wrIdx;
  logic [FREE_LOG:0]                      nReq, nAlloc, nFree, commitCntExt;
  logic [FREE_LOG:0]                      freeCountNext, commitCountNext;
  logic                                   allocFire;

  assign freeRegs = {freeReg3_i, freeReg2_i, freeReg1_i, freeReg0_i};
  assign {physReg3_o, physReg2_o, physReg1_o, physReg0_o} = physRegs;

  // The stall depends on registered state only. This keeps any path from
  // reqVector_i out of the stall.
  assign stallFreeList_o = (freeCount < (FREE_LOG+1)'(DISPATCH_WIDTH));
  assign freeCount_o     = freeCount;

  generate
    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : gLane
      rename_free_list_lane #(
        .LANE(k), .FREE_ENTRIES(FREE_ENTRIES), .FREE_LOG(FREE_LOG), .PHY_LOG(PHY_LOG)
      ) uLane (
        .reqMask (reqVector_i[k:0]),
        .headPtr (headPtr),
        .entries (entries),
        .physReg (physRegs[k])
      );
    end
  endgenerate

  always_comb begin
    nReq = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) nReq = nReq + (FREE_LOG+1)'(reqVector_i[k]);
    // Release slots pack densely from the tail, just as the read lanes do.
    nFree = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      wrIdx[k] = tailPtr + nFree[FREE_LOG-1:0];
      nFree    = nFree + (FREE_LOG+1)'(freeValid_i[k]);
    end
    allocFire       = allocReady_i & ~stallFreeList_o & ~flush_i;
    nAlloc          = allocFire ? nReq : '0;
    commitCntExt    = (FREE_LOG+1)'(commitAllocCnt_i);
    freeCountNext   = freeCount - nAlloc + nFree;
    commitCountNext = commitCount - commitCntExt + nFree;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FREE_ENTRIES; i++) entries[i] <= PHY_LOG'(ARCH_REGS + i);
      headPtr       <= '0;
      tailPtr       <= '0;
      commitHeadPtr <= '0;
      freeCount     <= (FREE_LOG+1)'(FREE_ENTRIES);
      commitCount   <= (FREE_LOG+1)'(FREE_ENTRIES);
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (freeValid_i[k]) entries[wrIdx[k]] <= freeRegs[k];
      tailPtr       <= tailPtr + nFree[FREE_LOG-1:0];
      commitHeadPtr <= commitHeadPtr + commitCntExt[FREE_LOG-1:0];
      commitCount   <= commitCountNext;
      // On a flush, the speculative state restarts from the retired view.
      // Releases made in the same cycle are already folded into commitCountNext.
      if (flush_i) begin
        headPtr   <= commitHeadPtr + commitCntExt[FREE_LOG-1:0];
        freeCount <= commitCountNext;
      end else begin
        headPtr   <= headPtr + nAlloc[FREE_LOG-1:0];
        freeCount <= freeCountNext;
      end
    end
  end

  // Illegal-input checks. There is no recovery path in hardware.
  // The number of allocations in flight is commitCount - freeCount, because both
  // counters see the same releases.
  always @(posedge clk) begin
    if (!reset) begin
      assert (FREE_ENTRIES == PHY_REGS - ARCH_REGS && FREE_ENTRIES == (1 << FREE_LOG));
      assert (int'(freeCount) + int'(nFree) <= FREE_ENTRIES);
      assert (commitAllocCnt_i <= 3'd4);
      assert (commitCntExt <= commitCount - freeCount);
    end
  end
endmodule

// File: tb/tb_rename_free_list.sv
module tb_rename_free_list;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush_i, allocReady_i;
  logic [3:0] reqVector_i, freeValid_i;
  logic [6:0] freeReg0_i, freeReg1_i, freeReg2_i, freeReg3_i;
  logic [2:0] commitAllocCnt_i;
  logic [6:0] physReg0_o, physReg1_o, physReg2_o, physReg3_o;
  logic       stallFreeList_o;
  logic [6:0] freeCount_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  rename_free_list dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .allocReady_i(allocReady_i),
    .reqVector_i(reqVector_i), .freeValid_i(freeValid_i),
    .freeReg0_i(freeReg0_i), .freeReg1_i(freeReg1_i), .freeReg2_i(freeReg2_i), .freeReg3_i(freeReg3_i),
    .commitAllocCnt_i(commitAllocCnt_i),
    .physReg0_o(physReg0_o), .physReg1_o(physReg1_o), .physReg2_o(physReg2_o), .physReg3_o(physReg3_o),
    .stallFreeList_o(stallFreeList_o), .freeCount_o(freeCount_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string t, input int e);
    exp_t x;
    x.tag = t;
    x.exp = 32'(e);
    sb.push_back(x);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard observed=%0d expected=<empty queue>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic expPhys(input string t, input int p0, input int p1, input int p2, input int p3);
    push({t, ".p0"}, p0); push({t, ".p1"}, p1); push({t, ".p2"}, p2); push({t, ".p3"}, p3);
  endtask
  task automatic popPhys();
    pop(32'(physReg0_o)); pop(32'(physReg1_o)); pop(32'(physReg2_o)); pop(32'(physReg3_o));
  endtask
  task automatic expCnt(input string t, input int fc, input int st);
    push({t, ".count"}, fc); push({t, ".stall"}, st);
  endtask
  task automatic popCnt();
    pop(32'(freeCount_o)); pop(32'(stallFreeList_o));
  endtask

  task automatic setIn(input logic ar, input logic [3:0] rv, input logic [3:0] fv,
                       input logic [6:0] f0, input logic [6:0] f1, input logic [6:0] f2,
                       input logic [6:0] f3, input logic [2:0] cac, input logic fl);
    allocReady_i = ar; reqVector_i = rv; freeValid_i = fv;
    freeReg0_i = f0; freeReg1_i = f1; freeReg2_i = f2; freeReg3_i = f3;
    commitAllocCnt_i = cac; flush_i = fl;
  endtask

  task automatic alloc4();  setIn(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0); endtask
  task automatic idle();    setIn(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0); endtask
  task automatic cyc();     @(posedge clk); #1; endtask
  task automatic doReset(); idle(); reset = 1'b1; #2; reset = 1'b0; cyc(); endtask

  initial begin
    idle();
    #1 reset = 1'b1;
    #1;
    // Reset image: entries hold 32..95 in order
    reqVector_i = 4'b1111;
    expCnt("rst", 64, 0);
    expPhys("rstRead", 32, 33, 34, 35);
    #1 popCnt(); popPhys();
    reqVector_i = 4'b0000;
    expPhys("rstNoReq", 0, 0, 0, 0);
    #1 popPhys();
    cyc();
    reset = 1'b0;

    // Sparse request 1010 from head 0
    setIn(1'b1, 4'b1010, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0);
    expPhys("sparse", 0, 32, 0, 33);
    #2 popPhys();
    cyc();
    expCnt("sparseCnt", 62, 0); popCnt();
    alloc4();
    expPhys("afterSparse", 34, 35, 36, 37);
    #2 popPhys();
    cyc();
    expCnt("afterSparseCnt", 58, 0); popCnt();

    // Drain the whole list 4 at a time
    doReset();
    for (int c = 0; c < 16; c++) begin
      alloc4();
      expPhys($sformatf("fill%0d", c), 32+4*c, 33+4*c, 34+4*c, 35+4*c);
      expCnt($sformatf("fillCnt%0d", c), 64-4*c, 0);
      #2 popPhys(); popCnt();
      cyc();
    end
    alloc4();
    expCnt("empty", 0, 1); popCnt();
    cyc();
    expCnt("emptyHold", 0, 1); popCnt();

    // Wrap: release 62 tags (entry i gets 20+i), drain to 2, then release across the wrap
    for (int c = 0; c < 15; c++) begin
      setIn(1'b0, 4'b0000, 4'b1111, 7'(20+4*c), 7'(21+4*c), 7'(22+4*c), 7'(23+4*c), 3'd0, 1'b0);
      cyc();
    end
    setIn(1'b0, 4'b0000, 4'b0011, 80, 81, 0, 0, 3'd0, 1'b0);
    cyc();
    expCnt("refill", 62, 0); popCnt();
    for (int c = 0; c < 15; c++) begin
      alloc4();
      expPhys($sformatf("refillRead%0d", c), 20+4*c, 21+4*c, 22+4*c, 23+4*c);
      #2 popPhys();
      cyc();
    end
    expCnt("wrapPre", 2, 1); popCnt();
    setIn(1'b0, 4'b0000, 4'b1111, 10, 11, 12, 13, 3'd0, 1'b0);
    cyc();
    expCnt("wrapRel", 6, 0); popCnt();
    alloc4();
    expPhys("wrapRead", 80, 81, 10, 11);
    #2 popPhys();
    cyc();
    expCnt("wrapAfter", 2, 1); popCnt();
    setIn(1'b0, 4'b1111, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0);
    expPhys("wrapTail", 12, 13, 22, 23);
    #2 popPhys();

    // Same-cycle alloc 4 and release 3 at freeCount 8
    doReset();
    for (int c = 0; c < 14; c++) begin alloc4(); cyc(); end
    expCnt("simPre", 8, 0); popCnt();
    setIn(1'b1, 4'b1111, 4'b0111, 1, 2, 3, 0, 3'd0, 1'b0);
    expPhys("simRead", 88, 89, 90, 91);
    #2 popPhys();
    cyc();
    expCnt("simCnt", 7, 0); popCnt();
    alloc4();
    expPhys("simOld", 92, 93, 94, 95);
    #2 popPhys();
    cyc();
    expCnt("simLow", 3, 1); popCnt();
    setIn(1'b0, 4'b1111, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0);
    expPhys("simNew", 1, 2, 3, 35);
    #2 popPhys();

    // Flush: 12 speculative, retire 4, then flush with 2 retiring and one release
    doReset();
    for (int c = 0; c < 3; c++) begin alloc4(); cyc(); end
    setIn(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 3'd4, 1'b0);
    cyc();
    expCnt("preFlush", 52, 0); popCnt();
    setIn(1'b1, 4'b1111, 4'b0001, 5, 0, 0, 0, 3'd2, 1'b1);
    cyc();
    expCnt("flushCnt", 59, 0); popCnt();
    alloc4();
    expPhys("flushRead", 38, 39, 40, 41);
    #2 popPhys();
    cyc();
    expCnt("postFlush", 55, 0); popCnt();

    // Async reset mid-run at freeCount 17, head 23
    doReset();
    for (int c = 0; c < 16; c++) begin alloc4(); cyc(); end
    for (int c = 0; c < 10; c++) begin
      setIn(1'b0, 4'b0000, 4'b1111, 7'(64+4*c), 7'(65+4*c), 7'(66+4*c), 7'(67+4*c), 3'd0, 1'b0);
      cyc();
    end
    for (int c = 0; c < 5; c++) begin alloc4(); cyc(); end
    setIn(1'b1, 4'b0111, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0);
    cyc();
    expCnt("preRst", 17, 0); popCnt();
    setIn(1'b0, 4'b0001, 4'b0000, 0, 0, 0, 0, 3'd0, 1'b0);
    expPhys("preRstHead", 87, 0, 0, 0);
    #1 popPhys();
    reqVector_i = 4'b1111;
    reset = 1'b1;
    #1;
    expCnt("asyncRst", 64, 0);
    expPhys("asyncRstRead", 32, 33, 34, 35);
    popCnt(); popPhys();
    #1 reset = 1'b0;
    alloc4();
    #1;
    expPhys("postRstRead", 32, 33, 34, 35);
    popPhys();
    cyc();
    expCnt("postRstCnt", 60, 0); popCnt();
    expPhys("postRstNext", 36, 37, 38, 39);
    #1 popPhys();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
